// File: rtl/num_board_builder.sv
// Neighbour-count builder: walks every cell of the active board, reads its eight
// neighbours from the mine map and writes the mine count into the number board.
module num_board_builder #(
    parameter int SIZE_EASY   = 8,
    parameter int SIZE_MEDIUM = 10,
    parameter int SIZE_HARD   = 16,
    parameter int XY_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      level,
    output logic            busy,
    output logic            done,
    output logic            mine_rd_en,
    output logic [XY_W-1:0] mine_rd_x,
    output logic [XY_W-1:0] mine_rd_y,
    input  logic            mine_rd_data,
    output logic            num_wr_en,
    output logic [XY_W-1:0] num_wr_x,
    output logic [XY_W-1:0] num_wr_y,
    output logic [3:0]      num_wr_data,
    output logic [2:0]      state_dbg
);

    // Handshake: start is a one-cycle request taken only in IDLE; busy covers the
    // whole scan; done pulses once, the cycle after the final count write.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [XY_W-1:0] LAST_EASY   = XY_W'(SIZE_EASY - 1);
    localparam logic [XY_W-1:0] LAST_MEDIUM = XY_W'(SIZE_MEDIUM - 1);
    localparam logic [XY_W-1:0] LAST_HARD   = XY_W'(SIZE_HARD - 1);

    localparam logic signed [XY_W:0] OFS_M1 = '1;
    localparam logic signed [XY_W:0] OFS_Z0 = '0;
    localparam logic signed [XY_W:0] OFS_P1 = {{XY_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [2:0]        slot;
    logic [XY_W-1:0]   cx, cy;
    logic [XY_W-1:0]   n_last;
    logic [3:0]        acc;
    logic              rd_pend;

    logic signed [XY_W:0] dx, dy, nx, ny;
    logic                 in_board;
    logic                 last_x, last_y;

    always_comb begin
        dx = OFS_Z0;
        dy = OFS_Z0;
        case (slot)
            3'd0: begin dx = OFS_M1; dy = OFS_M1; end
            3'd1: begin dx = OFS_Z0; dy = OFS_M1; end
            3'd2: begin dx = OFS_P1; dy = OFS_M1; end
            3'd3: begin dx = OFS_M1; dy = OFS_Z0; end
            3'd4: begin dx = OFS_P1; dy = OFS_Z0; end
            3'd5: begin dx = OFS_M1; dy = OFS_P1; end
            3'd6: begin dx = OFS_Z0; dy = OFS_P1; end
            default: begin dx = OFS_P1; dy = OFS_P1; end
        endcase
    end

    // One extra sign bit keeps -1 distinct from the top of the coordinate range.
    assign nx = $signed({1'b0, cx}) + dx;
    assign ny = $signed({1'b0, cy}) + dy;
    assign in_board = !nx[XY_W] && (nx[XY_W-1:0] <= n_last) &&
                      !ny[XY_W] && (ny[XY_W-1:0] <= n_last);
    assign last_x = (cx == n_last);
    assign last_y = (cy == n_last);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mine_rd_en  = 1'b0;
        mine_rd_x   = '0;
        mine_rd_y   = '0;
        num_wr_en   = 1'b0;
        num_wr_x    = '0;
        num_wr_y    = '0;
        num_wr_data = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = (level == 2'd0) ? S_DONE : S_READ;
            end
            S_READ: begin
                busy       = 1'b1;
                mine_rd_en = in_board;
                mine_rd_x  = nx[XY_W-1:0];
                mine_rd_y  = ny[XY_W-1:0];
                if (slot == 3'd7) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy       = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                num_wr_en   = 1'b1;
                num_wr_x    = cx;
                num_wr_y    = cy;
                num_wr_data = acc;
                state_next  = (last_x && last_y) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read data arrives one cycle after its strobe, so the strobe is delayed to qualify it.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= '0;
            cx      <= '0;
            cy      <= '0;
            n_last  <= '0;
            acc     <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= mine_rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        slot <= '0;
                        cx   <= '0;
                        cy   <= '0;
                        acc  <= '0;
                        case (level)
                            2'd1:    n_last <= LAST_EASY;
                            2'd2:    n_last <= LAST_MEDIUM;
                            default: n_last <= LAST_HARD;
                        endcase
                    end
                end
                S_READ: begin
                    slot <= slot + 3'd1;
                    acc  <= acc + {3'b000, rd_pend & mine_rd_data};
                end
                S_DRAIN: begin
                    acc <= acc + {3'b000, rd_pend & mine_rd_data};
                end
                S_WRITE: begin
                    acc <= '0;
                    if (last_x) begin
                        cx <= '0;
                        cy <= cy + XY_W'(1);
                    end else begin
                        cx <= cx + XY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_num_board_builder.sv
// Bench for num_board_builder: mine-map responder, neighbour-count model feeding
// an expected-write queue, per-cycle busy/done timing and read-address checks.
module tb_num_board_builder;

    localparam int XY_W = 5;
    localparam int W    = 30;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [1:0]      level;
    logic            busy, done, mine_rd_en, mine_rd_data, num_wr_en;
    logic [XY_W-1:0] mine_rd_x, mine_rd_y, num_wr_x, num_wr_y;
    logic [3:0]      num_wr_data;
    logic [2:0]      state_dbg;

    always #5 clk = ~clk;

    num_board_builder #(.SIZE_EASY(8), .SIZE_MEDIUM(10), .SIZE_HARD(16), .XY_W(XY_W)) dut (
        .clk(clk), .rst(rst), .start(start), .level(level), .busy(busy), .done(done),
        .mine_rd_en(mine_rd_en), .mine_rd_x(mine_rd_x), .mine_rd_y(mine_rd_y),
        .mine_rd_data(mine_rd_data), .num_wr_en(num_wr_en), .num_wr_x(num_wr_x),
        .num_wr_y(num_wr_y), .num_wr_data(num_wr_data), .state_dbg(state_dbg)
    );

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic mine_map[16][16];
    logic rd_next = 1'b0;
    int   t0 = 0, active = 0, busy_end = 0, done_at = -1, cur_n = 0;
    int   rd_total = 0, wr_total = 0, done_seen = 0, rd_cell0 = 0, exp_rd = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: strobed reads return the map bit next cycle, otherwise noise.
    always @(posedge clk) begin
        #1 mine_rd_data = rd_next;
    end

    always @(negedge clk) begin
        int rel, k, cxm, cym, ddx, ddy;
        logic ok;
        logic [W-1:0] got, want;
        rel = cyc - t0;
        if (mine_rd_en && mine_rd_x < 16 && mine_rd_y < 16)
            rd_next = mine_map[mine_rd_y][mine_rd_x];
        else
            rd_next = 1'($urandom_range(0, 1));
        if (mine_rd_en) begin
            rd_total++;
            if (rel >= 1 && rel <= 8) rd_cell0++;
            if (active != 0 && cur_n > 0 && rel >= 1) begin
                k   = (rel - 1) / 10;
                cxm = k % cur_n;
                cym = k / cur_n;
                ddx = int'(mine_rd_x) - cxm;
                ddy = int'(mine_rd_y) - cym;
                ok  = (int'(mine_rd_x) < cur_n) && (int'(mine_rd_y) < cur_n) &&
                      ddx >= -1 && ddx <= 1 && ddy >= -1 && ddy <= 1 && !(ddx == 0 && ddy == 0);
                check_eq("rd_addr", 32'(ok), 32'd1);
            end
        end
        if (num_wr_en) begin
            wr_total++;
            check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {num_wr_x, num_wr_y, num_wr_data, 16'(rel)};
                check_eq("wr_xy_data_cycle", 32'(got), 32'(want));
            end
        end
        if (done) done_seen++;
        if (active != 0) begin
            check_eq("busy", 32'(busy), 32'(rel >= 1 && rel <= busy_end));
            check_eq("done", 32'(done), 32'(rel == done_at));
        end
    end

    task automatic clear_map(input logic v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) mine_map[y][x] = v;
    endtask

    task automatic build(input int n);
        exp_rd = 0;
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                int c;
                c = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int xx, yy;
                        xx = x + dx;
                        yy = y + dy;
                        if (!(dx == 0 && dy == 0) && xx >= 0 && xx < n && yy >= 0 && yy < n) begin
                            exp_rd++;
                            c += int'(mine_map[yy][xx]);
                        end
                    end
                end
                exp_q.push_back({5'(x), 5'(y), 4'(c), 16'(10 + 10 * (y * n + x))});
            end
        end
    endtask

    function automatic int size_of(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 8;
            2'd2:    return 10;
            2'd3:    return 16;
            default: return 0;
        endcase
    endfunction

    task automatic launch(input logic [1:0] lvl, input int n, input int b_end, input int d_at);
        rd_total = 0; wr_total = 0; done_seen = 0; rd_cell0 = 0;
        @(negedge clk);
        start = 1'b1; level = lvl; t0 = cyc;
        cur_n = n; busy_end = b_end; done_at = d_at; active = 1;
        @(negedge clk);
        start = 1'b0; level = 2'($urandom_range(0, 3));
    endtask

    task automatic run_level(input logic [1:0] lvl, input string name);
        int n;
        n = size_of(lvl);
        exp_q.delete();
        build(n);
        launch(lvl, n, 10 * n * n, 10 * n * n + 1);
        repeat (10 * n * n + 3) @(negedge clk);
        active = 0;
        check_eq({name, "_wr_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({name, "_wr_total"}, 32'(wr_total), 32'(n * n));
        check_eq({name, "_rd_total"}, 32'(rd_total), 32'(exp_rd));
        check_eq({name, "_done_cnt"}, 32'(done_seen), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, 32'({busy, done, mine_rd_en, mine_rd_x, mine_rd_y,
                           num_wr_en, num_wr_x, num_wr_y, num_wr_data}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; level = 2'd0;
        clear_map(1'b0);
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        check_eq("reset_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_level(2'd1, "easy_zero");

        mine_map[0][0] = 1'b1;
        run_level(2'd1, "easy_corner");
        check_eq("corner_cell0_reads", 32'(rd_cell0), 32'd3);

        clear_map(1'b1);
        run_level(2'd3, "hard_ones");

        clear_map(1'b0);
        mine_map[9][9] = 1'b1;
        run_level(2'd2, "medium_far");

        run_level(2'd0, "none");

        // Re-start mid-scan is ignored; reset at cycle 300 aborts without done.
        clear_map(1'b0);
        for (int i = 0; i < 40; i++)
            mine_map[$urandom_range(0, 7)][$urandom_range(0, 7)] = 1'b1;
        exp_q.delete();
        build(8);
        while (exp_q.size() > 30) void'(exp_q.pop_back());
        launch(2'd1, 8, 300, -1);
        while (cyc - t0 < 100) @(negedge clk);
        start = 1'b1; level = 2'd0;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 300) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_quiet("abort_quiet");
            @(negedge clk);
        end
        active = 0;
        check_eq("abort_wr_left", 32'(exp_q.size()), 32'd0);
        check_eq("abort_wr_total", 32'(wr_total), 32'd30);
        check_eq("abort_no_done", 32'(done_seen), 32'd0);

        run_level(2'd1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/num_board_builder.md
Name: num_board_builder

Overview:
- Sequencer that fills the neighbour-count board after mine placement and before the number-glyph lookup reads it.
- On a start pulse it walks every cell of the active board size and reads the 8 neighbours from the mine-map RAM through a 1-cycle-latency read port.
- It writes each cell's count into the number-board storage through a write port.
- It signals completion with a one-cycle done pulse; the game FSM waits for that pulse before enabling board redraw.

Parameters:
- SIZE_EASY, 8, board edge length for level 1
- SIZE_MEDIUM, 10, board edge length for level 2
- SIZE_HARD, 16, board edge length for level 3
- XY_W, 5, width of cell coordinates

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  one-cycle request to rebuild the board; ignored while busy
- level  input  2  0 = none, 1 = easy, 2 = medium, 3 = hard; sampled only when start is accepted
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last write
- mine_rd_en  output  1  mine-map read strobe
- mine_rd_x  output  XY_W  read column
- mine_rd_y  output  XY_W  read row
- mine_rd_data  input  1  mine bit; valid in the cycle after an accepted mine_rd_en
- num_wr_en  output  1  count write strobe
- num_wr_x  output  XY_W  write column
- num_wr_y  output  XY_W  write row
- num_wr_data  output  4  neighbour count, 0..8 (4 bits so that 8 does not wrap)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and accumulator cleared. Reset mid-scan aborts the scan: no further writes, and no done pulse is generated.
- Board size N: latched from level at start (8, 10 or 16). level 0 goes to DONE directly with no reads and no writes.
- Start timing: start is accepted only in IDLE. With start sampled at cycle 0, busy=1 from cycle 1.
- Scan order: y outer, x inner, from (0,0) to (N-1,N-1).
- Per-cell schedule, exactly 10 cycles:
  - READ0..READ7: one neighbour per cycle, in the order (dx,dy) = (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
  - Out-of-board neighbour (x+dx or y+dy outside 0..N-1): mine_rd_en=0 and the slot contributes 0. Coordinates may still be driven.
  - In-board neighbour: mine_rd_en=1 with its coordinates.
  - Accumulation: mine_rd_data is added into the accumulator in the cycle after each strobed read.
  - DRAIN: absorbs the READ7 response.
  - WRITE: num_wr_en=1 for exactly one cycle with num_wr_x/y set to the current cell and num_wr_data = accumulator. The accumulator clears for the next cell.
- The cell's own mine bit is never read and never counted.
- Cell timing: cell k (0-based) uses cycles 1+10k .. 10+10k; its write lands at cycle 10+10k.
- Completion: the last write is at cycle 10·N². At cycle 10·N²+1: done=1 and busy=0, FSM returns to IDLE. A new start is accepted from cycle 10·N²+2.
- Level 0: done=1 at cycle 1, busy stays 0.
- Totals: 640 / 1000 / 2560 cycles of scan for easy / medium / hard.
- Output quiet rules: num_wr_en=0 outside WRITE; mine_rd_en=0 in IDLE, DRAIN, WRITE and DONE. Address outputs may hold their last values when the strobe is low.
- Concurrency: start while busy is ignored, and level changes while busy are ignored. start and rst in the same cycle: rst wins.
- Coordinate arithmetic: dx/dy are applied in XY_W+1 signed width before the bounds check, so that -1 never aliases to 31.

Test Plan:
- level=1, all-zero mine map, start at cycle 0 -> 64 writes, all data 0, in raster order; first write at cycle 10, (7,7) at cycle 640; done at cycle 641.
- level=1, single mine at (0,0) -> (1,0), (0,1), (1,1) written as 1, all other cells 0 (including (0,0)); cell (0,0) issues exactly 3 mine_rd_en pulses.
- level=3, all-ones mine map -> corners 3, edges 5, interior 8 (num_wr_data=4'd8); done at cycle 2561.
- level=2, mine at (9,9) -> only (8,8), (9,8), (8,9) equal 1; no read ever targets x or y = 10; done at cycle 1001.
- level=0 -> done pulse at cycle 1, zero reads and zero writes; busy never high.
- level=1 run with start re-pulsed at cycle 100 and rst pulsed at cycle 300 -> second start ignored; after rst, all outputs 0 from cycle 301, no done pulse; a fresh start then completes normally.
